gpio_reg_arbiter: RTL and testbench

Round-robin arbiter that shares the single register-bus slave port of the GPIO register file among `NumReq` register-bus masters, for example a core-side AXI-Lite bridge and a debug/DMA path. It sits between the masters and the GPIO block. Each transaction goes through a grant-and-hold state machine: the winner's request is latched and driven downstream until the target answers. A watchdog counter returns an error response when the target never asserts ready.

---
 rtl/gpio_reg_arbiter.sv | 164 ++++++++++++++++
 tb/tb_gpio_reg_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_reg_arbiter.sv
// Round-robin grant-and-hold arbiter sharing the GPIO register-bus slave port
// between several masters, with a watchdog that aborts transactions the target never answers.
package gpio_reg_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module gpio_reg_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256,
  parameter type         reg_req_t     = gpio_reg_arbiter_pkg::reg_req_t,
  parameter type         reg_rsp_t     = gpio_reg_arbiter_pkg::reg_rsp_t,
  localparam int unsigned GntWidth     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  reg_req_t            req_i [NumReq],
  output reg_rsp_t            rsp_o [NumReq],
  output reg_req_t            req_o,
  input  reg_rsp_t            rsp_i,
  output logic [GntWidth-1:0] grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned WdWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [WdWidth-1:0] WdLast =
      (TimeoutCycles > 0) ? WdWidth'(TimeoutCycles - 1) : '0;
  localparam int unsigned ReqBits = AddrWidth + DataWidth + DataWidth / 8 + 2;
  localparam int unsigned RspBits = DataWidth + 2;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  if ($bits(reg_req_t) != ReqBits) begin : g_req_width_check
    $error("reg_req_t width does not match AddrWidth/DataWidth");
  end
  if ($bits(reg_rsp_t) != RspBits) begin : g_rsp_width_check
    $error("reg_rsp_t width does not match DataWidth");
  end

  logic [0:0]          state_r;
  logic [GntWidth-1:0] rr_ptr_r;
  logic [GntWidth-1:0] grant_r;
  reg_req_t            req_r;
  logic [WdWidth-1:0]  wd_cnt_r;

  logic [GntWidth-1:0] win_s;
  logic                any_s;
  int unsigned         idx_s;
  reg_req_t            req_sel_s;
  logic [GntWidth-1:0] next_ptr_s;
  logic                timeout_s;
  logic                done_s;

  // Winner search: first valid request at or above rr_ptr_r, wrapping modulo NumReq.
  always_comb begin
    win_s = '0;
    any_s = 1'b0;
    idx_s = 32'd0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx_s = 32'(rr_ptr_r) + i;
      if (idx_s >= NumReq) begin
        idx_s = idx_s - NumReq;
      end else begin
        idx_s = idx_s;
      end
      if (!any_s && req_i[GntWidth'(idx_s)].valid) begin
        any_s = 1'b1;
        win_s = GntWidth'(idx_s);
      end else begin
        any_s = any_s;
      end
    end
  end

  always_comb begin
    req_sel_s       = req_i[win_s];
    req_sel_s.valid = 1'b1;
  end

  assign next_ptr_s = (32'(grant_r) == NumReq - 1) ? '0 : grant_r + 1'b1;
  // A target ready in the threshold cycle is a normal completion, never an abort.
  assign timeout_s  = (TimeoutCycles != 0) && (state_r == StBusy) &&
                      (wd_cnt_r == WdLast) && !rsp_i.ready;
  assign done_s     = (state_r == StBusy) && (rsp_i.ready || timeout_s);

  // Grant-and-hold sequencing, round-robin pointer and watchdog counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= StIdle;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      req_r    <= '0;
      wd_cnt_r <= '0;
    end else begin
      case (state_r)
        StIdle: begin
          if (any_s) begin
            grant_r  <= win_s;
            req_r    <= req_sel_s;
            wd_cnt_r <= '0;
            state_r  <= StBusy;
          end
        end
        StBusy: begin
          if (done_s) begin
            state_r  <= StIdle;
            rr_ptr_r <= next_ptr_s;
          end else begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
          end
        end
        default: state_r <= StIdle;
      endcase
    end
  end

  // Downstream request from the latched copy; response routed only to the current owner.
  always_comb begin
    req_o = '0;
    for (int unsigned j = 0; j < NumReq; j++) begin
      rsp_o[GntWidth'(j)] = '0;
    end
    if (state_r == StBusy) begin
      req_o = req_r;
      for (int unsigned j = 0; j < NumReq; j++) begin
        if (GntWidth'(j) == grant_r) begin
          if (timeout_s) begin
            rsp_o[GntWidth'(j)].rdata = '0;
            rsp_o[GntWidth'(j)].error = 1'b1;
            rsp_o[GntWidth'(j)].ready = 1'b1;
          end else begin
            rsp_o[GntWidth'(j)] = rsp_i;
          end
        end else begin
          rsp_o[GntWidth'(j)] = '0;
        end
      end
    end else begin
      req_o = '0;
    end
  end

  assign grant_o   = grant_r;
  assign busy_o    = (state_r == StBusy);
  assign timeout_o = timeout_s;

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Randomized scoreboard bench: a transaction-level model predicts each grant and its
// response timing; a monitor process checks the DUT outputs every cycle against the queue.
module tb_gpio_reg_arbiter;
  import gpio_reg_arbiter_pkg::*;

  localparam int N = 3;
  localparam int T = 4;

  typedef struct {
    int          mst;
    reg_req_t    req;
    int          grant;
    int          fin;
    bit          tmo;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i;
  reg_req_t   req_i [N];
  reg_rsp_t   rsp_o [N];
  reg_req_t   req_o;
  reg_rsp_t   rsp_i;
  logic [1:0] grant_o;
  logic       busy_o;
  logic       timeout_o;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];

  gpio_reg_arbiter #(
    .NumReq(N), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(T)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .rsp_o(rsp_o), .req_o(req_o),
    .rsp_i(rsp_i), .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Driver plus reference model: masters, target and the expected transaction list.
  initial begin
    bit          act = 1'b0;
    int          act_mst = 0, act_grant = 0, act_fin = 0, act_w = 0;
    logic [31:0] act_rdata = 32'd0;
    logic        act_err = 1'b0;
    int          ptr = 0;
    bit          rst_prev = 1'b0, rst_now;
    int          c, win, w;
    int          wtab [8] = '{0, 0, 1, 2, 3, 3, 4, 7};
    exp_t        e;

    rst_i = 1'b1;
    rsp_i = '0;
    for (int k = 0; k < N; k++) req_i[k] = '0;
    repeat (3) @(posedge clk);
    for (int n = 0; n < 3020; n++) begin
      #1;
      c = cyc;
      if (rst_prev) begin
        if (act) void'(q.pop_front());
        act = 1'b0;
        ptr = 0;
      end
      if (act && c == act_fin + 1) begin
        req_i[act_mst].valid = 1'b0;
        act = 1'b0;
      end
      rst_now = (n >= 300) && (n < 3000) && act && (c > act_grant) && (c < act_fin) &&
                ($urandom_range(0, 9) == 0);
      if (act && c > act_grant && !rst_now && $urandom_range(0, 3) == 0) begin
        req_i[act_mst] = reg_req_t'({$urandom, $urandom, $urandom});
      end
      for (int k = 0; k < N; k++) begin
        if (act && k == act_mst) continue;
        if (n >= 3000) req_i[k].valid = 1'b0;
        else if (n == 0 && k == 0) begin
          req_i[0].addr  = 32'h0000_0010;
          req_i[0].write = 1'b1;
          req_i[0].wdata = 32'hA5A5_0001;
          req_i[0].wstrb = 4'hF;
          req_i[0].valid = 1'b1;
        end else if (n > 0 && !req_i[k].valid && $urandom_range(0, 9) < 4) begin
          req_i[k].addr  = $urandom;
          req_i[k].write = 1'($urandom_range(0, 1));
          req_i[k].wdata = $urandom;
          req_i[k].wstrb = 4'($urandom);
          req_i[k].valid = 1'b1;
        end
      end
      if (!act && !rst_now) begin
        win = -1;
        for (int i = 0; i < N; i++) begin
          if (win < 0 && req_i[(ptr + i) % N].valid) win = (ptr + i) % N;
        end
        if (win >= 0) begin
          w = (n == 0) ? 0 : wtab[$urandom_range(0, 7)];
          e.mst   = win;
          e.req   = req_i[win];
          e.grant = c;
          e.tmo   = (w >= T);
          e.fin   = e.tmo ? c + T : c + 1 + w;
          e.rdata = e.tmo ? 32'd0 : $urandom;
          e.err   = e.tmo ? 1'b1 : 1'($urandom_range(0, 1));
          q.push_back(e);
          act = 1'b1; act_mst = win; act_grant = c; act_fin = e.fin; act_w = w;
          act_rdata = e.rdata; act_err = e.err;
          ptr = (win + 1) % N;
        end
      end
      rst_i = rst_now;
      if (act && act_w < T && c == act_grant + 1 + act_w) begin
        rsp_i.ready = 1'b1;
        rsp_i.rdata = act_rdata;
        rsp_i.error = act_err;
      end else begin
        rsp_i.ready = (!act || c == act_grant) ? ($urandom_range(0, 7) == 0) : 1'b0;
        rsp_i.rdata = $urandom;
        rsp_i.error = 1'($urandom_range(0, 1));
      end
      rst_prev = rst_now;
      @(posedge clk);
    end
    #1;
    chk("queue_drained", 128'(q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: compares DUT outputs each cycle against the scoreboard head.
  initial begin
    bit       prev_rst = 1'b1;
    int       last_gnt = 0;
    bit       busy_e, fin_e;
    reg_req_t er;
    reg_rsp_t r;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("reset_req_o", req_o, 128'd0);
        for (int j = 0; j < N; j++) chk("reset_rsp_o", rsp_o[j], 128'd0);
        chk("reset_busy_o", busy_o, 128'd0);
        chk("reset_timeout_o", timeout_o, 128'd0);
        chk("reset_grant_o", grant_o, 128'd0);
        last_gnt = 0;
      end else begin
        busy_e = (q.size() > 0) && (cyc > q[0].grant);
        chk("busy_o", busy_o, busy_e);
        chk("grant_o", grant_o, busy_e ? q[0].mst : last_gnt);
        if (busy_e) begin
          fin_e = (cyc == q[0].fin);
          er = q[0].req;
          er.valid = 1'b1;
          chk("req_o", req_o, er);
          for (int j = 0; j < N; j++) begin
            if (j == q[0].mst) begin
              if (fin_e) begin
                r.rdata = q[0].rdata;
                r.error = q[0].err;
                r.ready = 1'b1;
              end else begin
                r = rsp_i;
              end
            end else begin
              r = '0;
            end
            chk("rsp_o_busy", rsp_o[j], r);
          end
          chk("timeout_o", timeout_o, fin_e && q[0].tmo);
          if (fin_e) begin
            last_gnt = q[0].mst;
            void'(q.pop_front());
          end
        end else begin
          chk("idle_req_valid", req_o.valid, 128'd0);
          for (int j = 0; j < N; j++) chk("rsp_o_idle", rsp_o[j], 128'd0);
          chk("idle_timeout_o", timeout_o, 128'd0);
        end
      end
      prev_rst = rst_i;
    end
  end

endmodule
